// File: rtl/fwd_scoreboard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fwd_scoreboard_unit                                                      |
// | EX-stage operand forwarding over NSTAGE sources plus a per-register      |
// | scoreboard for long-latency writebacks. Optional: FWD_STALL_CNT_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fwd_scoreboard_unit #(
  parameter  int NSTAGE = 2,
  parameter  int NREG   = 32,
  parameter  int RAW    = 5,
  localparam int SELW   = $clog2(NSTAGE + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAW-1:0]        rs1_ex,
  input  logic [RAW-1:0]        rs2_ex,
  input  logic                  use_rs1_ex,
  input  logic                  use_rs2_ex,
  input  logic                  wr_en_ex,
  input  logic [RAW-1:0]        rd_ex,
  input  logic [NSTAGE*RAW-1:0] stg_rd,
  input  logic [NSTAGE-1:0]     stg_we,
  input  logic                  issue_valid,
  input  logic                  complete_valid,
  input  logic [RAW-1:0]        complete_rd,
  output logic [SELW-1:0]       forward_a,
  output logic [SELW-1:0]       forward_b,
  output logic                  stall_ex,
  output logic                  issue_accept,
  output logic                  sb_busy,
  output logic                  sb_err,
  output logic [31:0]           stall_cnt
);

  localparam logic [SELW-1:0] SEL_CPL = SELW'(NSTAGE + 1);

  logic [NREG-1:0] pending_q, pending_d;
  logic            sb_err_q, sb_err_d;
  logic            raw_a, raw_b, waw, stall, accept;
  logic [SELW-1:0] fwd_a, fwd_b;

  function automatic logic is_pending(input logic [RAW-1:0] r);
    is_pending = (32'(r) < NREG) ? pending_q[r] : 1'b0;
  endfunction

  function automatic logic cpl_hit(input logic [RAW-1:0] r);
    cpl_hit = complete_valid && (complete_rd == r);
  endfunction

  // Stage loop runs oldest-first so the youngest matching stage wins.
  function automatic logic [SELW-1:0] fwd_sel(input logic [RAW-1:0] rs, input logic use_rs);
    logic [SELW-1:0] sel;
    sel = '0;
    if (use_rs && rs != '0) begin
      if (cpl_hit(rs)) sel = SEL_CPL;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (stg_we[k] && stg_rd[k*RAW +: RAW] == rs) sel = SELW'(k + 1);
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a  = fwd_sel(rs1_ex, use_rs1_ex);
    fwd_b  = fwd_sel(rs2_ex, use_rs2_ex);
    raw_a  = use_rs1_ex && is_pending(rs1_ex) && !cpl_hit(rs1_ex);
    raw_b  = use_rs2_ex && is_pending(rs2_ex) && !cpl_hit(rs2_ex);
    waw    = wr_en_ex && is_pending(rd_ex) && !cpl_hit(rd_ex);
    stall  = raw_a | raw_b | waw;
    accept = issue_valid && !stall;
  end

  // Clear first, then set, so a same-cycle issue to a completing register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    if (complete_valid) begin
      if (is_pending(complete_rd)) pending_d[complete_rd] = 1'b0;
      else                         sb_err_d = 1'b1;
    end
    if (accept && rd_ex != '0 && 32'(rd_ex) < NREG) pending_d[rd_ex] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = reset ? 32'd0 : stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

  assign forward_a    = reset ? '0 : fwd_a;
  assign forward_b    = reset ? '0 : fwd_b;
  assign stall_ex     = stall & ~reset;
  assign issue_accept = accept & ~reset;
  assign sb_busy      = (|pending_q) & ~reset;
  assign sb_err       = sb_err_q & ~reset;

endmodule
`default_nettype wire

// File: doc/fwd_scoreboard_unit.md
# fwd_scoreboard_unit

Parametrised operand-forwarding and hazard unit for the EX stage of the pipelined RISC-V core. It generalises MEM/WB forwarding to NSTAGE forwarding sources. It also adds a per-register scoreboard for long-latency writebacks (divider, wait-stated loads). It forwards completing long-latency results on the same cycle they return. It raises stall_ex for RAW and WAW hazards on pending registers.

## Interface
- NSTAGE, 2: number of pipeline forwarding sources after EX; index 0 is youngest (MEM), NSTAGE-1 oldest (WB).
- NREG, 32: architectural registers; register 0 is hard-wired zero.
- RAW, 5: register address width, ≥ clog2(NREG).
- SELW, clog2(NSTAGE+2): forward-select width (derived localparam).
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rs1_ex, rs2_ex  input  RAW  EX source registers.
- use_rs1_ex, use_rs2_ex  input  1  source actually read by the EX instruction.
- wr_en_ex  input  1  EX instruction writes a register.
- rd_ex  input  RAW  EX destination register.
- stg_rd  input  NSTAGE*RAW  packed stage destinations, stage k at [k*RAW +: RAW].
- stg_we  input  NSTAGE  per-stage RegWrite.
- issue_valid  input  1  EX instruction is a long-latency op; its rd becomes pending.
- complete_valid  input  1  long-latency result on the completion bus this cycle.
- complete_rd  input  RAW  destination of completing result.
- forward_a, forward_b  output  SELW  operand select: 0 regfile, k in 1..NSTAGE = stage k-1, NSTAGE+1 = completion bus.
- stall_ex  output  1  hold EX and upstream this cycle.
- issue_accept  output  1  issue_valid && !stall_ex.
- sb_busy  output  1  any register pending.
- sb_err  output  1  sticky: completion for non-pending register.
- stall_cnt  output  32  stall-cycle counter (see Configuration).

## Operation
- Scoreboard: pending[NREG] register bits; pending[0] is constant 0.
- Set pending[rd_ex] when issue_accept && rd_ex != 0.
- Clear pending[complete_rd] when complete_valid && pending[complete_rd].
- Set and clear of the same register in the same cycle: set wins, so the bit stays 1.
- Completion with pending[complete_rd]==0 or complete_rd==0: no state change; sb_err set to 1 and held until reset.
- Forward select for operand A (B identical on rs2/use_rs2_ex):
  - If use_rs1_ex==0 or rs1_ex==0: select 0.
  - Else if some stage k has stg_we[k] and stg_rd[k]==rs1_ex: select k+1, with lowest k taking priority.
  - Else if complete_valid and complete_rd==rs1_ex: select NSTAGE+1.
  - Else: select 0.
- RAW hazard on an operand: the operand is used, nonzero, pending, and not matched by complete_valid/complete_rd this cycle.
- WAW hazard: wr_en_ex, rd_ex!=0, pending[rd_ex], and not completing this cycle.
- stall_ex = RAW(A) | RAW(B) | WAW.
- Issue is ignored when stall_ex=1; the instruction retries when held.
- sb_busy = OR of pending.
- All outputs are forced to 0 while reset is high.

## Timing
- forward_a/b, stall_ex and issue_accept are combinational from inputs and registered pending; there is zero-cycle latency.
- Scoreboard updates are visible to the next cycle: an issue at edge N makes a reader of rd in cycle N+1 stall.
- A completion bypasses the stall in its own cycle (select NSTAGE+1). The pending bit clears at the following edge.
- Reset: pending=0, sb_err=0, stall_cnt=0. The first cycle after reset deassertion behaves as an empty scoreboard.
- Reset mid-operation: all pending bits drop. Completions arriving later set sb_err; the pipeline must flush the long-latency units alongside.
- NSTAGE=2 encoding is 00 RF, 01 MEM, 10 WB, 11 completion.

## Configuration
- FWD_STALL_CNT_EN defined: stall_cnt increments by 1 on each rising edge with stall_ex=1 and reset=0. It saturates at 32'hFFFF_FFFF and clears on reset.
- FWD_STALL_CNT_EN undefined: stall_cnt tied to 32'd0 and no counter flops are built. All other behaviour is identical.

## Test plan
- MEM and WB both write x5, EX reads rs1=x5, rs2=x0 with both used -> forward_a=01, forward_b=00, stall_ex=0.
- Issue divide to x7 (accepted). Next cycle EX reads x7 -> stall_ex=1 until the complete_valid cycle with complete_rd=7. In that cycle forward_a=11 and stall_ex=0; pending[7]=0 after the edge.
- x9 pending, EX with wr_en_ex=1 and rd_ex=9 -> stall_ex=1, issue_accept=0. Complete x9 -> stall_ex drops in the same cycle.
- Same cycle: complete_rd=4 (pending) and an accepted issue to x4 -> pending[4] stays 1; the next reader of x4 stalls.
- complete_valid with complete_rd=12 not pending -> sb_err=1 and stays 1. Assert reset one cycle -> sb_err=0, sb_busy=0, stall_cnt=0.
- With FWD_STALL_CNT_EN, stall for 3 cycles -> stall_cnt=3. Without the macro, the same stimulus -> stall_cnt=0.
